// File: rtl/risc_ctrl_pkg.sv
// Shared types for the VeriRISC control sequencer: opcodes, phases and
// the opcode-class decode used by the strobe logic.
package risc_ctrl_pkg;

    localparam int OPW_LEGACY = 3;
    localparam int TMR_W      = 8;

    // Legacy values 0..7 are unchanged; 8..11 exist only in the extended set
    typedef enum logic [3:0] {
        OP_HLT = 4'd0,
        OP_SKZ = 4'd1,
        OP_ADD = 4'd2,
        OP_AND = 4'd3,
        OP_XOR = 4'd4,
        OP_LDA = 4'd5,
        OP_STO = 4'd6,
        OP_JMP = 4'd7,
        OP_OR  = 4'd8,
        OP_SUB = 4'd9,
        OP_LDI = 4'd10,
        OP_JNZ = 4'd11
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef struct packed {
        logic alu;
        logic skz;
        logic sto;
        logic jmp;
        logic jnz;
        logic ldi;
        logic hlt;
        logic bad;
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op, input logic ext);
        op_class_t c;
        c = '0;
        case (op)
            OP_HLT:                         c.hlt = 1'b1;
            OP_SKZ:                         c.skz = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: c.alu = 1'b1;
            OP_STO:                         c.sto = 1'b1;
            OP_JMP:                         c.jmp = 1'b1;
            OP_OR, OP_SUB:                  c.alu = ext;
            OP_LDI:                         c.ldi = ext;
            OP_JNZ:                         c.jnz = ext;
            default:                        c.bad = ext;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/risc_ctrl_seq_wait_timer.sv
// Memory wait-state counter: counts consecutive stalled cycles of one access
// and flags the stall cycle on which the limit is reached.
module risc_wait_timer
    import risc_ctrl_pkg::*;
#(
    parameter int WAIT_TMO = 15
) (
    input  logic clk,
    input  logic rst_,
    input  logic hold,
    output logic tmo
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(WAIT_TMO - 1);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt + TMR_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // A ready access in the limit cycle never reaches here because hold is low
    assign tmo = hold && (cnt == LAST);

endmodule

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle control sequencer for VeriRISC: eight-phase instruction cycle,
// memory wait-states with timeout, resumable HLT and sticky error halts.
module risc_ctrl_seq
    import risc_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int MEM_WAIT_EN = 1,
    parameter int WAIT_TMO    = 15
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    input  logic           resume,
    output logic           sel,
    output logic           rd,
    output logic           wr,
    output logic           ld_ir,
    output logic           ld_ac,
    output logic           ld_pc,
    output logic           inc_pc,
    output logic           data_e,
    output logic           imm_sel,
    output logic           halt,
    output logic           illegal,
    output logic           bus_err,
    output logic [2:0]     phase
);

    localparam logic EXT     = (OPW > OPW_LEGACY);
    localparam logic WAIT_ON = (MEM_WAIT_EN != 0);

    phase_t    phase_q;
    logic      halt_q;
    logic      illegal_q;
    logic      bus_err_q;
    logic [3:0] op_ext;
    op_class_t cls;
    logic      stall_pt;
    logic      hold;
    logic      tmo;

    assign op_ext = 4'(opcode);
    assign cls    = classify(op_ext, EXT);

    always_comb begin
        stall_pt = 1'b0;
        case (phase_q)
            PH_INST_FETCH: stall_pt = 1'b1;
            PH_OP_FETCH:   stall_pt = cls.alu;
            PH_STORE:      stall_pt = cls.sto;
            default:       stall_pt = 1'b0;
        endcase
    end

    assign hold = WAIT_ON && stall_pt && !halt_q && !mem_ready;

    risc_wait_timer #(
        .WAIT_TMO (WAIT_TMO)
    ) u_wait_timer (
        .clk  (clk),
        .rst_ (rst_),
        .hold (hold),
        .tmo  (tmo)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q   <= PH_INST_ADDR;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else if (halt_q) begin
            // Only a clean HLT halt can be resumed; error halts need rst_
            if (resume && !illegal_q && !bus_err_q) begin
                halt_q  <= 1'b0;
                phase_q <= PH_INST_ADDR;
            end
        end else if (tmo) begin
            halt_q    <= 1'b1;
            bus_err_q <= 1'b1;
        end else if (hold) begin
            phase_q <= phase_q;
        end else if (phase_q == PH_OP_ADDR && (cls.hlt || cls.bad)) begin
            halt_q    <= 1'b1;
            illegal_q <= cls.bad;
        end else begin
            phase_q <= phase_t'(phase_q + 3'd1);
        end
    end

    // Strobes decode the registered phase with the live opcode and zero flag
    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        ld_ir   = 1'b0;
        ld_ac   = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        data_e  = 1'b0;
        imm_sel = 1'b0;
        if (rst_ && !halt_q) begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = !cls.bad;
                end
                PH_OP_FETCH: begin
                    rd = cls.alu;
                end
                PH_ALU_OP: begin
                    rd     = cls.alu;
                    inc_pc = cls.skz && zero;
                    ld_pc  = cls.jmp || (cls.jnz && !zero);
                    data_e = cls.sto;
                end
                PH_STORE: begin
                    rd      = cls.alu;
                    ld_ac   = cls.alu || cls.ldi;
                    imm_sel = cls.ldi;
                    ld_pc   = cls.jmp || (cls.jnz && !zero);
                    data_e  = cls.sto;
                    wr      = cls.sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign halt    = halt_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Bench for risc_ctrl_seq: directed instruction scenarios followed by random
// instruction streams, all compared every cycle against a behavioural model.
module tb_risc_ctrl_seq;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, imm_sel;
    logic       halt, illegal, bus_err;
    logic [2:0] phase;
    logic [8:0] strb;

    risc_ctrl_seq #(
        .OPW         (4),
        .MEM_WAIT_EN (1),
        .WAIT_TMO    (TMO)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .data_e    (data_e),
        .imm_sel   (imm_sel),
        .halt      (halt),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Bit positions: sel 8, rd 7, wr 6, ld_ir 5, ld_ac 4, ld_pc 3, inc_pc 2, data_e 1, imm_sel 0
    assign strb = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, imm_sel};

    int total = 0;
    int bad   = 0;

    int m_phase;
    int m_wait;
    bit m_halt, m_ill, m_be;

    logic [8:0] last_strb;
    logic       last_halt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_alu(input int op);
        return (op == 2) || (op == 3) || (op == 4) || (op == 5) || (op == 8) || (op == 9);
    endfunction

    function automatic logic [8:0] ref_strb(input int ph, input int op, input bit z, input bit halted);
        logic [8:0] s;
        bit         alu, jump;
        s    = '0;
        alu  = is_alu(op);
        jump = (op == 7) || ((op == 11) && !z);
        if (halted) return '0;
        case (ph)
            0: s[8] = 1'b1;
            1: begin s[8] = 1'b1; s[7] = 1'b1; end
            2, 3: begin s[8] = 1'b1; s[7] = 1'b1; s[5] = 1'b1; end
            4: s[2] = (op < 12);
            5: s[7] = alu;
            6: begin
                s[7] = alu;
                s[2] = (op == 1) && z;
                s[3] = jump;
                s[1] = (op == 6);
            end
            default: begin
                s[7] = alu;
                s[4] = alu || (op == 10);
                s[0] = (op == 10);
                s[3] = jump;
                s[1] = (op == 6);
                s[6] = (op == 6);
            end
        endcase
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_halt  = 0;
        m_ill   = 0;
        m_be    = 0;
    endtask

    task automatic model_step(input int op, input bit rdy, input bit res);
        bit sp;
        if (m_halt) begin
            if (res && !m_ill && !m_be) begin
                m_halt  = 0;
                m_phase = 0;
            end
            m_wait = 0;
            return;
        end
        sp = (m_phase == 1) || ((m_phase == 5) && is_alu(op)) || ((m_phase == 7) && (op == 6));
        if (sp && !rdy) begin
            m_wait++;
            if (m_wait == TMO) begin
                m_be   = 1;
                m_halt = 1;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
            if ((m_phase == 4) && ((op == 0) || (op >= 12))) begin
                m_halt = 1;
                m_ill  = (op >= 12);
            end else begin
                m_phase = (m_phase + 1) % 8;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cyc(input int op, input bit z, input bit rdy, input bit res);
        opcode    = 4'(op);
        zero      = z;
        mem_ready = rdy;
        resume    = res;
        #1;
        check("strobes", 16'(strb), 16'(ref_strb(m_phase, op, z, m_halt)));
        check("phase", 16'(phase), 16'(m_phase));
        check("flags", {13'd0, halt, illegal, bus_err}, {13'd0, m_halt, m_ill, m_be});
        last_strb = strb;
        last_halt = halt;
        model_step(op, rdy, res);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        #1;
        check("rst_strobes", 16'(strb), 16'd0);
        check("rst_phase", 16'(phase), 16'd0);
        check("rst_flags", {13'd0, halt, illegal, bus_err}, 16'd0);
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        logic [7:0] rd_mask, ac_mask, pc_mask;
        int         n_wr, n_inc, n_halt;
        int         op_r;
        bit         z_r, slow, rdy_r, res_r;

        rst_      = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        resume    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // ADD through all eight phases
        rd_mask = '0;
        ac_mask = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(2, 0, 1, 0);
            rd_mask[i] = last_strb[7];
            ac_mask[i] = last_strb[4];
        end
        check("add_rd_phases", 16'(rd_mask), 16'h00ee);
        check("add_ldac_phases", 16'(ac_mask), 16'h0080);
        check("add_wrap", 16'(phase), 16'd0);

        // STO with three wait-states in the store phase
        do_reset();
        for (int i = 0; i < 7; i++) cyc(6, 0, 1, 0);
        n_wr = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(6, 0, (i == 3), 0);
            n_wr += int'(last_strb[6] & last_strb[1]);
        end
        check("sto_wr_cycles", 16'(n_wr), 16'd4);
        check("sto_next_phase", 16'(phase), 16'd0);
        check("sto_no_buserr", 16'(bus_err), 16'd0);

        // LDA operand fetch that never completes
        do_reset();
        for (int i = 0; i < 5; i++) cyc(5, 0, 1, 0);
        for (int i = 0; i < TMO; i++) cyc(5, 0, 0, 0);
        check("lda_timeout", {14'd0, halt, bus_err}, 16'h0003);
        cyc(5, 0, 1, 1);
        cyc(5, 0, 1, 0);
        check("lda_resume_ignored", {14'd0, halt, bus_err}, 16'h0003);

        // LDA completing in the last allowed stall cycle
        do_reset();
        for (int i = 0; i < 5; i++) cyc(5, 0, 1, 0);
        for (int i = 0; i < TMO - 1; i++) cyc(5, 0, 0, 0);
        cyc(5, 0, 1, 0);
        check("lda_limit_ok", {13'd0, halt, bus_err, 1'b0}, 16'd0);
        check("lda_limit_phase", 16'(phase), 16'd6);

        // HLT, then resume on the fifth halted cycle
        do_reset();
        n_inc  = 0;
        n_halt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0);
            n_inc += int'(last_strb[2]);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, (i == 4));
            n_inc  += int'(last_strb[2]);
            n_halt += int'(last_halt);
        end
        check("hlt_halt_cycles", 16'(n_halt), 16'd5);
        check("hlt_inc_pc", 16'(n_inc), 16'd1);
        check("hlt_resumed", {13'd0, phase}, 16'd0);
        check("hlt_cleared", 16'(halt), 16'd0);

        // JNZ taken and not taken, then an illegal opcode
        pc_mask = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(11, 0, 1, 0);
            pc_mask[i] = last_strb[3];
        end
        check("jnz_taken", 16'(pc_mask), 16'h00c0);
        pc_mask = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(11, 1, 1, 0);
            pc_mask[i] = last_strb[3];
        end
        check("jnz_not_taken", 16'(pc_mask), 16'd0);
        n_inc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(13, 0, 1, 0);
            n_inc += int'(last_strb[2]);
        end
        check("illegal_no_inc", 16'(n_inc), 16'd0);
        check("illegal_flags", {14'd0, halt, illegal}, 16'h0003);
        cyc(13, 0, 1, 1);
        cyc(13, 0, 1, 0);
        check("illegal_resume_ignored", {14'd0, halt, illegal}, 16'h0003);

        // Reset while a store is stalled
        do_reset();
        for (int i = 0; i < 7; i++) cyc(6, 0, 1, 0);
        cyc(6, 0, 0, 0);
        cyc(6, 0, 0, 0);
        opcode    = 4'd6;
        mem_ready = 1'b0;
        #1;
        check("stall_wr_before", 16'(wr), 16'd1);
        #1;
        rst_ = 1'b0;
        #1;
        check("async_wr_drop", 16'(wr), 16'd0);
        check("async_phase", 16'(phase), 16'd0);
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
        cyc(6, 0, 1, 0);

        // Random instruction streams
        op_r = 2;
        z_r  = 0;
        slow = 0;
        for (int i = 0; i < 3000; i++) begin
            if (((m_ill || m_be) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 299) == 0)) begin
                do_reset();
                continue;
            end
            if ((m_phase == 0) && !m_halt) begin
                if ($urandom_range(0, 3) == 0) op_r = int'($urandom_range(0, 15));
                else                           op_r = int'($urandom_range(1, 11));
                z_r  = bit'($urandom_range(0, 1));
                slow = ($urandom_range(0, 7) == 0);
            end
            rdy_r = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            res_r = m_halt && ($urandom_range(0, 3) == 0);
            cyc(op_r, z_r, rdy_r, res_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
